serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor: computes D = A - B (- Bin) one bit per clock, LSB first.
//  A single full-subtractor cell and a borrow flip-flop sit behind a shift datapath.
//  Pairs with the combinational adder cells as the subtract direction of the arithmetic set.
//  Serves area-constrained datapaths that can tolerate WIDTH-cycle latency.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  A       in   WIDTH  minuend, latched on accepted start
//  B       in   WIDTH  subtrahend, latched on accepted start
//  Bin     in   1      borrow-in, latched on accepted start (only with SUB_BORROW_IN_EN)
//  busy    out  1      high while in SHIFT
//  done    out  1      one-cycle pulse, result valid
//  D       out  WIDTH  difference; held from done until next accepted start
//  B_out   out  1      final borrow (1 = A < B (+Bin) unsigned); held with D
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; busy=0, done=0, D=0, B_out=0; count, shift regs, borrow=0.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE : start=1 at edge k -> latch A,B into shift regs, borrow<=0 (or Bin), count<=0, ->SHIFT.
//    SHIFT: per edge: d = a0^b0^bor; bor <= (~a0&b0) | (~(a0^b0)&bor);
//           result reg shifts right, d enters MSB; A/B regs shift right; count++.
//           After WIDTH bit-edges (edge k+WIDTH) -> DONE, D <= final result, B_out <= final bor.
//    DONE : done=1 for exactly this one cycle; unconditional -> IDLE next edge.
//  - Latency: start sampled at edge k -> done high during cycle after edge k+WIDTH.
//  - busy=1 exactly in SHIFT (WIDTH cycles); done and busy never high together.
//  - start while SHIFT or DONE: ignored, no re-latch, no queueing.
//  - A/B/Bin changes after acceptance: no effect on the running operation.
//  - D/B_out must not change during SHIFT; they update only on entry to DONE.
//  - Arithmetic: modulo 2^WIDTH, unsigned borrow; A==B (Bin=0) -> D=0, B_out=0.
//  - Reset mid-SHIFT: operation aborted, outputs cleared, no done pulse.
//  - Count register sized $clog2(WIDTH)+1; no wrap before WIDTH reached.
// CONFIGURATION
//  SUB_BORROW_IN_EN defined: Bin port present; initial borrow = Bin latched at start;
//    enables chaining multiple instances for wider subtraction.
//  SUB_BORROW_IN_EN undefined: Bin port absent; initial borrow fixed 0.
// TESTING
//  1. WIDTH=8, A=8'h5A, B=8'h23, start 1 cycle -> busy 8 cycles, done 1 cycle, D=8'h37, B_out=0.
//  2. A=8'h00, B=8'h01 -> D=8'hFF, B_out=1; A=8'hC3, B=8'hC3 -> D=8'h00, B_out=0.
//  3. Start pulse mid-SHIFT with A=8'hFF,B=8'h00 -> ignored; first result unchanged, single done.
//  4. rst asserted at 4th SHIFT cycle -> busy=0, done never pulses, D=0, B_out=0; next start ok.
//  5. SUB_BORROW_IN_EN, A=8'h10, B=8'h01, Bin=1 -> D=8'h0E, B_out=0; A=0,B=0,Bin=1 -> D=8'hFF, B_out=1.
//  6. Exhaustive WIDTH=4 sweep of all A,B (and Bin) vs golden model; done exactly WIDTH+1 edges after start.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B (- Bin), LSB first, one full-subtractor cell.
// Optional borrow-in port and initial borrow enabled by defining SUB_BORROW_IN_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SUB_BORROW_IN_EN
    input  logic             Bin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bor;
    logic [CW-1:0]    r_cnt;

    logic             w_bin;
    logic             w_d;
    logic             w_bor_nxt;
    logic [WIDTH-1:0] w_res_nxt;

`ifdef SUB_BORROW_IN_EN
    assign w_bin = Bin;
`else
    assign w_bin = 1'b0;
`endif

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_bor;
    assign w_bor_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            B_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_res   <= '0;
                        r_bor   <= w_bin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_nxt;
                    r_bor <= w_bor_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    // D/B_out are only published once the last bit is through the cell.
                    if (r_cnt == LAST) begin
                        D       <= w_res_nxt;
                        B_out   <= w_bor_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
